// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the multi-cycle control sequencer:
//   - state_t  : sequencer state encoding (also exported on the debug port)
//   - OP_*     : RV64I-subset major opcodes understood by the sequencer
//   - ALU_*    : ALU operation codes driven onto alu_op
//   - iclass_t : instruction class produced by rv_decode
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_IMM = 3'd1,
        CLS_LD  = 3'd2,
        CLS_SD  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_ILL = 3'd5
    } iclass_t;

endpackage

// File: rtl/rv_decode.sv
// ---------------------------------------------------------------------------
// rv_decode
// Purely combinational classifier for the instruction held in the datapath IR.
// Ports:
//   opcode   in  7 : IR[6:0]
//   funct3   in  3 : IR[14:12]
//   funct7_5 in  1 : IR[30]
//   cls      out 3 : instruction class (iclass_t encoding)
//   alu_op   out 4 : ALU operation the instruction needs in EXEC
//   illegal  out 1 : encoding is outside the supported subset
// ---------------------------------------------------------------------------
module rv_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] cls,
    output logic [3:0] alu_op,
    output logic       illegal
);

    always_comb begin
        cls     = CLS_ILL;
        alu_op  = ALU_ADD;
        illegal = 1'b1;
        case (opcode)
            OP_R: begin
                // IR[30] only selects SUB; with AND/OR it marks an
                // unsupported encoding.
                case (funct3)
                    3'b000: begin
                        cls     = CLS_R;
                        alu_op  = funct7_5 ? ALU_SUB : ALU_ADD;
                        illegal = 1'b0;
                    end
                    3'b111: begin
                        if (!funct7_5) begin
                            cls     = CLS_R;
                            alu_op  = ALU_AND;
                            illegal = 1'b0;
                        end
                    end
                    3'b110: begin
                        if (!funct7_5) begin
                            cls     = CLS_R;
                            alu_op  = ALU_OR;
                            illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    cls     = CLS_IMM;
                    illegal = 1'b0;
                end
            end
            OP_LD: begin
                if (funct3 == 3'b011) begin
                    cls     = CLS_LD;
                    illegal = 1'b0;
                end
            end
            OP_SD: begin
                if (funct3 == 3'b011) begin
                    cls     = CLS_SD;
                    illegal = 1'b0;
                end
            end
            OP_BEQ: begin
                if (funct3 == 3'b000) begin
                    cls     = CLS_BEQ;
                    alu_op  = ALU_SUB;
                    illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control sequencer for the full_path datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction
// and data memories (req held until ack), drives datapath enables and mux
// selects, and counts retired instructions.
// Ports:
//   clk, rst (sync, active-low)
//   opcode/funct3/funct7_5 : latched IR fields from the datapath
//   alu_zero               : ALU result == 0 (branch condition)
//   imem_ack/dmem_ack      : memory completion, meaningful only with req
//   imem_req, dmem_req, dmem_we          : memory requests
//   ir_we, pc_we, pc_sel                 : IR / PC control
//   alu_src_imm, alu_op                  : ALU control
//   reg_we, mem_to_reg                   : register-file writeback control
//   retire, instret                      : retirement pulse and counter
//   halted                               : illegal instruction seen
//   state                                : current state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             alu_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             alu_src_imm,
    output logic [3:0]       alu_op,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [2:0]       state
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] instret_q;

    logic [2:0] dec_cls;
    logic [3:0] dec_alu_op;
    logic       dec_illegal;

    rv_decode u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .cls      (dec_cls),
        .alu_op   (dec_alu_op),
        .illegal  (dec_illegal)
    );

    // State register and retired-instruction counter. Reset wins over any
    // pending ack, so an in-flight request simply disappears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode. The ack-qualified outputs (ir_we/pc_we in
    // FETCH, retire for a store in MEM) follow the ack in the same cycle so
    // that the transfer completes on the edge that leaves the state.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_AND;
        reg_we      = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = dec_illegal ? ST_HALT : ST_EXEC;
            end

            ST_EXEC: begin
                alu_op = dec_alu_op;
                case (dec_cls)
                    CLS_R: begin
                        state_d = ST_WB;
                    end
                    CLS_IMM: begin
                        alu_src_imm = 1'b1;
                        state_d     = ST_WB;
                    end
                    CLS_LD, CLS_SD: begin
                        alu_src_imm = 1'b1;
                        state_d     = ST_MEM;
                    end
                    CLS_BEQ: begin
                        // Branch target is old_pc+imm; PC+4 was already
                        // loaded during FETCH, so not-taken needs no write.
                        retire  = 1'b1;
                        pc_we   = alu_zero;
                        pc_sel  = alu_zero;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_HALT;
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_cls == CLS_SD);
                if (dmem_ack) begin
                    if (dec_cls == CLS_SD) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (dec_cls == CLS_LD);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int CW = 4;

    // Encodings written out independently of the design package.
    localparam logic [6:0] T_OP_R   = 7'b0110011;
    localparam logic [6:0] T_OP_IMM = 7'b0010011;
    localparam logic [6:0] T_OP_LD  = 7'b0000011;
    localparam logic [6:0] T_OP_SD  = 7'b0100011;
    localparam logic [6:0] T_OP_BEQ = 7'b1100011;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;

    localparam int K_R = 0, K_IMM = 1, K_LD = 2, K_SD = 3, K_BEQ = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          funct7_5 = 1'b0;
    logic          alu_zero = 1'b0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel;
    logic          alu_src_imm, reg_we, mem_to_reg, retire, halted;
    logic [3:0]    alu_op;
    logic [CW-1:0] instret;
    logic [2:0]    state;

    int n_checks = 0;
    int n_err    = 0;
    int exp_cnt  = 0;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_zero    (alu_zero),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .reg_we      (reg_we),
        .mem_to_reg  (mem_to_reg),
        .retire      (retire),
        .instret     (instret),
        .halted      (halted),
        .state       (state)
    );

    always #5 clk = ~clk;

    // All outputs except instret, bundled for per-cycle comparison.
    logic [17:0] act;
    assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm,
                  alu_op, reg_we, mem_to_reg, retire, halted, state};

    function automatic logic [17:0] pk(logic ireq, logic dreq, logic dwe, logic irwe,
                                       logic pcwe, logic pcs, logic asrc, logic [3:0] aop,
                                       logic rwe, logic m2r, logic ret, logic hlt,
                                       logic [2:0] st);
        return {ireq, dreq, dwe, irwe, pcwe, pcs, asrc, aop, rwe, m2r, ret, hlt, st};
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    // Reference: expected outputs in cycle k of an instruction, counted from
    // its first FETCH cycle, derived from the phase walk FETCH(iw+1), DECODE,
    // EXEC, MEM(dw+1) for memory ops, WB for register-writing ops.
    function automatic logic [17:0] model_out(int k, int kind, logic [3:0] aop,
                                              logic zero, int iw, int dw);
        int r = k;
        bit is_mem = (kind == K_LD) || (kind == K_SD);
        bit has_wb = (kind == K_R) || (kind == K_IMM) || (kind == K_LD);
        if (r <= iw) begin
            if (r == iw) return pk(1,0,0,1,1,0,0,4'b0,0,0,0,0,3'd1);
            return pk(1,0,0,0,0,0,0,4'b0,0,0,0,0,3'd1);
        end
        r -= iw + 1;
        if (r == 0) return pk(0,0,0,0,0,0,0,4'b0,0,0,0,0,3'd2);
        if (r == 1) begin
            if (kind == K_BEQ) return pk(0,0,0,0,zero,zero,0,aop,0,0,1,0,3'd3);
            return pk(0,0,0,0,0,0,(kind != K_R),aop,0,0,0,0,3'd3);
        end
        r -= 2;
        if (is_mem) begin
            if (r <= dw) return pk(0,1,(kind == K_SD),0,0,0,0,4'b0,0,0,
                                   (kind == K_SD) && (r == dw),0,3'd4);
            r -= dw + 1;
        end
        if (has_wb && r == 0) return pk(0,0,0,0,0,0,0,4'b0,1,(kind == K_LD),1,0,3'd5);
        return pk(1,0,0,0,0,0,0,4'b0,0,0,0,0,3'd1);
    endfunction

    function automatic int model_len(int kind, int iw, int dw);
        int n = iw + 3;
        if (kind == K_LD || kind == K_SD) n += dw + 1;
        if (kind == K_R || kind == K_IMM || kind == K_LD) n += 1;
        return n;
    endfunction

    // Runs one legal instruction from its first FETCH cycle (caller is at
    // posedge+1 with the DUT in FETCH). Acks outside the matching memory
    // phase are randomised to show they are ignored while req is low.
    task automatic run_one(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic zero, input int kind,
                           input logic [3:0] aop, input int iw, input int dw,
                           input int cycles);
        int mk;
        bit in_mem;
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        alu_zero = zero;
        for (int k = 0; k < cycles; k++) begin
            mk     = k - (iw + 3);
            in_mem = ((kind == K_LD) || (kind == K_SD)) && (mk >= 0) && (mk <= dw);
            imem_ack = (k <= iw) ? (k == iw) : 1'($urandom_range(0, 1));
            dmem_ack = in_mem ? (mk == dw) : 1'($urandom_range(0, 1));
            #1;
            chk({tag, "_outs"}, 32'(act), 32'(model_out(k, kind, aop, zero, iw, dw)));
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        exp_cnt++;
        chk({tag, "_next_fetch"}, 32'(state), 32'd1);
        chk({tag, "_instret"}, 32'(instret), 32'(exp_cnt % (1 << CW)));
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_outs", 32'(act), 32'd0);
            chk("rst_instret", 32'(instret), 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("idle_after_release", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        exp_cnt = 0;
    endtask

    task automatic run_illegal(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input int hold);
        do_reset();
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        imem_ack = 1'b1;
        #1;
        chk({tag, "_fetch"}, 32'(act), 32'(pk(1,0,0,1,1,0,0,4'b0,0,0,0,0,3'd1)));
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        #1;
        chk({tag, "_decode"}, 32'(act), 32'(pk(0,0,0,0,0,0,0,4'b0,0,0,0,0,3'd2)));
        @(posedge clk);
        #1;
        for (int i = 0; i < hold; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            #1;
            chk({tag, "_halt"}, 32'(act), 32'(pk(0,0,0,0,0,0,0,4'b0,0,0,0,1,3'd6)));
            chk({tag, "_instret"}, 32'(instret), 32'd0);
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    typedef struct {
        string      tag;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         kind;
        logic [3:0] aop;
        int         iw;
        int         dw;
        int         cycles;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"add",     T_OP_R,   3'b000, 1'b0, 1'b0, K_R,   A_ADD, 0, 0, 4});
        vecs.push_back('{"sub",     T_OP_R,   3'b000, 1'b1, 1'b0, K_R,   A_SUB, 0, 0, 4});
        vecs.push_back('{"and",     T_OP_R,   3'b111, 1'b0, 1'b0, K_R,   A_AND, 1, 0, 5});
        vecs.push_back('{"or",      T_OP_R,   3'b110, 1'b0, 1'b1, K_R,   A_OR,  0, 0, 4});
        vecs.push_back('{"addi",    T_OP_IMM, 3'b000, 1'b0, 1'b0, K_IMM, A_ADD, 2, 0, 6});
        vecs.push_back('{"ld_wait", T_OP_LD,  3'b011, 1'b0, 1'b0, K_LD,  A_ADD, 2, 3, 10});
        vecs.push_back('{"ld",      T_OP_LD,  3'b011, 1'b0, 1'b1, K_LD,  A_ADD, 0, 0, 5});
        vecs.push_back('{"sd",      T_OP_SD,  3'b011, 1'b0, 1'b0, K_SD,  A_ADD, 0, 0, 4});
        vecs.push_back('{"sd_wait", T_OP_SD,  3'b011, 1'b0, 1'b0, K_SD,  A_ADD, 1, 2, 7});
        vecs.push_back('{"beq_t",   T_OP_BEQ, 3'b000, 1'b0, 1'b1, K_BEQ, A_SUB, 0, 0, 3});
        vecs.push_back('{"beq_nt",  T_OP_BEQ, 3'b000, 1'b0, 1'b0, K_BEQ, A_SUB, 0, 0, 3});

        // Reset, release, then the vector table back to back.
        do_reset();
        foreach (vecs[i])
            run_one(vecs[i].tag, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero,
                    vecs[i].kind, vecs[i].aop, vecs[i].iw, vecs[i].dw, vecs[i].cycles);

        // Randomised legal instruction stream with random wait states; the
        // counter wraps several times along the way.
        for (int n = 0; n < 60; n++) begin
            int kind = int'($urandom_range(0, 4));
            int iw   = int'($urandom_range(0, 3));
            int dw   = int'($urandom_range(0, 3));
            logic z  = 1'($urandom_range(0, 1));
            logic [6:0] op;
            logic [2:0] f3;
            logic f7 = 1'b0;
            logic [3:0] aop = A_ADD;
            case (kind)
                K_R: begin
                    op = T_OP_R;
                    case ($urandom_range(0, 3))
                        0: begin f3 = 3'b000; end
                        1: begin f3 = 3'b000; f7 = 1'b1; aop = A_SUB; end
                        2: begin f3 = 3'b111; aop = A_AND; end
                        default: begin f3 = 3'b110; aop = A_OR; end
                    endcase
                end
                K_IMM: begin op = T_OP_IMM; f3 = 3'b000; end
                K_LD:  begin op = T_OP_LD;  f3 = 3'b011; end
                K_SD:  begin op = T_OP_SD;  f3 = 3'b011; end
                default: begin op = T_OP_BEQ; f3 = 3'b000; aop = A_SUB; end
            endcase
            run_one("rand", op, f3, f7, z, kind, aop, iw, dw, model_len(kind, iw, dw));
        end

        // Illegal encodings halt without retiring; reset is the only exit.
        run_illegal("ill_ff",   7'b1111111, 3'b000, 1'b0, 20);
        run_illegal("ill_andf7", T_OP_R,    3'b111, 1'b1, 2);
        run_illegal("ill_addi", T_OP_IMM,   3'b001, 1'b0, 2);
        run_illegal("ill_ld",   T_OP_LD,    3'b010, 1'b0, 2);

        // Reset in the middle of a load's MEM wait with an ack pending.
        do_reset();
        run_one("pre_mid", T_OP_IMM, 3'b000, 1'b0, 1'b0, K_IMM, A_ADD, 0, 0, 4);
        opcode   = T_OP_LD;
        funct3   = 3'b011;
        funct7_5 = 1'b0;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_mem_req", 32'(dmem_req), 32'd1);
        rst      = 1'b0;
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("mid_req_drop", 32'(dmem_req), 32'd0);
        chk("mid_state", 32'(state), 32'd0);
        chk("mid_instret", 32'(instret), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_idle", 32'(act), 32'd0);
        @(posedge clk); #1;
        chk("mid_refetch", 32'(act), 32'(pk(1,0,0,0,0,0,0,4'b0,0,0,0,0,3'd1)));
        exp_cnt = 0;

        // Counter wrap: 16 retires bring a 4-bit instret back to 0.
        for (int n = 0; n < 16; n++)
            run_one("wrap", T_OP_IMM, 3'b000, 1'b0, 1'b0, K_IMM, A_ADD, 0, 0, 4);
        chk("wrap_zero", 32'(instret), 32'd0);
        run_one("wrap_plus1", T_OP_BEQ, 3'b000, 1'b0, 1'b1, K_BEQ, A_SUB, 0, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
